pen_matrix_ctrl: RTL and testbench
==================================

// Module: pen_matrix_ctrl
// PURPOSE
//  Parametrised LED-matrix scanner with integrated light-pen position capture and on-chip
//  frame buffer. Each frame: a display sweep (one row per slot), then a probe sweep lighting
//  one pixel per slot. Pen sensor high at the end of a probe slot yields a hit (row,col), which
//  draws or erases that pixel. Sits between debounced control/state logic and matrix pins.
// PARAMETERS
//  ROWS       8     matrix rows (>=2); RW=$clog2(ROWS)
//  COLS       8     matrix columns (>=2); CW=$clog2(COLS)
//  CH         2     colour channels per pixel (ch0=red, ch1=green, ...)
//  SLOT_CYC   1000  clocks per slot (>=BLANK_CYC+2)
//  BLANK_CYC  50    leading clocks of each slot with all outputs off (anti-ghosting)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous reset, active low
//  en         in   1        1 = scanning; 0 = outputs off, sequencer held at frame start
//  mode       in   2        0 view, 1 draw, 2 erase, 3 = view
//  color      in   CH       channel mask written on draw hit
//  clear      in   1        single-cycle request: zero the frame buffer
//  pen_i      in   1        raw light-pen sensor, active high, asynchronous
//  row_o      out  ROWS     row drive, active low
//  col_o      out  CH*COLS  column drive, active high; bits [k*COLS +: COLS] = channel k
//  pos_valid  out  1        one-cycle hit strobe
//  pos_row    out  RW       hit row, held until next hit
//  pos_col    out  CW       hit column, held until next hit
//  clear_busy out  1        high while clear sweep runs
//  frame_tick out  1        one-cycle pulse on last clock of each frame
// BEHAVIOUR
//  - Reset: row_o all 1, col_o all 0, pos_valid/clear_busy/frame_tick 0, pos_row/pos_col 0,
//    frame buffer all 0, sequencer S_DISP row 0 slot cycle 0, synchroniser cleared.
//  - pen_i passes a 2-flop synchroniser; "pen" below means the synchronised value.
//  - States: S_DISP (slots r=0..ROWS-1) -> S_PROBE (slots r-major, c=0..COLS-1) -> S_DISP.
//    S_PROBE skipped when mode is view at the end of the last display slot. mode/color
//    sampled at S_DISP->S_PROBE transition, held for the whole probe sweep.
//  - Slot counter sc 0..SLOT_CYC-1. Outputs registered: sc<BLANK_CYC -> all off; otherwise
//    S_DISP: row_o[r]=0, col_o[k*COLS+c]=fb[r][c][k]; S_PROBE: row_o[r]=0, all CH bits of
//    column c lit, every other column off.
//  - Hit: in S_PROBE, pen==1 at sc==SLOT_CYC-1 and no hit yet this sweep. Next clock:
//    pos_valid=1, pos_row/pos_col = slot coords, and fb[r][c] <= color (draw) or 0 (erase).
//    Only the first hit per probe sweep is reported; later hits ignored until next sweep.
//  - frame_tick on sc==SLOT_CYC-1 of the final slot. Frame length:
//    (ROWS+ROWS*COLS)*SLOT_CYC in draw/erase, ROWS*SLOT_CYC in view.
//  - Clear: clear while !clear_busy -> clear_busy=1 next clock; one pixel zeroed per clock,
//    linear address 0..ROWS*COLS-1; clear_busy drops after ROWS*COLS clocks. clear while
//    busy ignored. Scanning continues during clear, showing partially cleared content.
//  - Pen writes while clear_busy: pos_valid/pos_* still reported, buffer write dropped.
//    clear and hit same cycle: clear starts, pen write dropped.
//  - en=0: outputs off, sequencer reset to S_DISP row 0 sc 0, no hits; clear still works.
//    en rising: frame restarts from row 0.
//  - Async reset mid-frame or mid-clear: immediate return to reset values, buffer zeroed.
// TESTING  (ROWS=COLS=4, CH=2, SLOT_CYC=8, BLANK_CYC=2)
//  - Reset released, en=1, mode=0: row_o=4'b1111 for sc 0..1 of each slot, row_o=4'b1110
//    sc 2..7 of slot 0, col_o=0; frame_tick every 32 clocks.
//  - mode=1, color=2'b01, pen high only during probe slot (2,1): one pos_valid, pos=(2,1);
//    next display slot row 2 drives col_o=8'b0000_0010.
//  - Then mode=2, pen high at slot (2,1): pos_valid, row 2 display col_o=0.
//  - Pen held high all frame in draw mode: exactly one pos_valid per frame at (0,0);
//    frame length 160 clocks.
//  - clear pulse with fb populated: clear_busy high 16 clocks, second clear mid-sweep
//    ignored; afterwards all display slots col_o=0; hit during clear leaves fb unchanged.
//  - rst_n low during probe slot (1,3) with clear_busy: all outputs at reset values
//    immediately; after release, frame restarts at display row 0, fb all 0.

Source files
------------

// File: rtl/pen_matrix_if.sv
// Signal bundle between the pen-matrix controller and its control logic / matrix pins.
// The slave modport is the controller's view of the bundle.
interface pen_matrix_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CH   = 2
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic                 en;
  logic [1:0]           mode;
  logic [CH-1:0]        color;
  logic                 clear;
  logic                 pen_i;
  logic [ROWS-1:0]      row_o;
  logic [CH*COLS-1:0]   col_o;
  logic                 pos_valid;
  logic [RW-1:0]        pos_row;
  logic [CW-1:0]        pos_col;
  logic                 clear_busy;
  logic                 frame_tick;

  modport master (
    output en, mode, color, clear, pen_i,
    input  row_o, col_o, pos_valid, pos_row, pos_col, clear_busy, frame_tick
  );

  modport slave (
    input  en, mode, color, clear, pen_i,
    output row_o, col_o, pos_valid, pos_row, pos_col, clear_busy, frame_tick
  );
endinterface

// File: rtl/pen_matrix_ctrl.sv
// LED-matrix scanner: display sweep then per-pixel probe sweep, light-pen hit capture,
// and an on-chip frame buffer drawn/erased by pen hits and zeroed by a linear clear sweep.
module pen_matrix_ctrl #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int CH        = 2,
  parameter int SLOT_CYC  = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  pen_matrix_if.slave     bus
);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int SCW  = $clog2(SLOT_CYC);
  localparam int NPIX = ROWS * COLS;
  localparam int AW   = $clog2(NPIX);

  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(SLOT_CYC - 1);
  localparam logic [SCW-1:0] SC_BLANK = SCW'(BLANK_CYC);
  localparam logic [AW-1:0]  PIX_LAST = AW'(NPIX - 1);

  typedef enum logic {S_DISP, S_PROBE} state_e;

  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [SCW-1:0]     sc_q, sc_d;
  logic [1:0]         mode_q, mode_d;
  logic [CH-1:0]      color_q, color_d;
  logic               hit_done_q, hit_done_d;
  logic               pen_s1_q, pen_s2_q;
  logic               clr_busy_q;
  logic [AW-1:0]      clr_addr_q;
  logic [ROWS-1:0]    row_out_q, row_out_d;
  logic [CH*COLS-1:0] col_out_q, col_out_d;
  logic               tick_q, tick_d;
  logic               pos_valid_q;
  logic [RW-1:0]      pos_row_q;
  logic [CW-1:0]      pos_col_q;
  logic [CH-1:0]      fb_q [NPIX];

  logic hit, clear_start, mode_active;

  function automatic logic [AW-1:0] pix_addr(input logic [RW-1:0] r, input int c);
    return AW'(int'(r) * COLS + c);
  endfunction

  assign mode_active = (bus.mode == 2'd1) || (bus.mode == 2'd2);
  assign hit         = bus.en && (state_q == S_PROBE) && (sc_q == SC_LAST) && pen_s2_q && !hit_done_q;
  assign clear_start = bus.clear && !clr_busy_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    sc_d       = sc_q + 1'b1;
    mode_d     = mode_q;
    color_d    = color_q;
    hit_done_d = hit_done_q || hit;
    if (!bus.en) begin
      state_d = S_DISP;
      row_d   = '0;
      col_d   = '0;
      sc_d    = '0;
    end else if (sc_q == SC_LAST) begin
      sc_d = '0;
      if (state_q == S_DISP) begin
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (mode_active) begin
            state_d    = S_PROBE;
            col_d      = '0;
            mode_d     = bus.mode;
            color_d    = bus.color;
            hit_done_d = 1'b0;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = S_DISP;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Outputs are derived from the next sequencer position so pins line up with sc_q.
  always_comb begin
    row_out_d = '1;
    col_out_d = '0;
    tick_d    = 1'b0;
    if (bus.en) begin
      if (sc_d >= SC_BLANK) begin
        row_out_d[row_d] = 1'b0;
        for (int k = 0; k < CH; k++) begin
          for (int c = 0; c < COLS; c++) begin
            if (state_d == S_DISP) col_out_d[k*COLS + c] = fb_q[pix_addr(row_d, c)][k];
            else                   col_out_d[k*COLS + c] = (col_d == CW'(c));
          end
        end
      end
      if (sc_d == SC_LAST && row_d == ROW_LAST)
        tick_d = (state_d == S_PROBE) ? (col_d == COL_LAST) : !mode_active;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the frame buffer is reset because a cleared display after reset is required behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DISP;
      row_q       <= '0;
      col_q       <= '0;
      sc_q        <= '0;
      mode_q      <= '0;
      color_q     <= '0;
      hit_done_q  <= 1'b0;
      pen_s1_q    <= 1'b0;
      pen_s2_q    <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_addr_q  <= '0;
      row_out_q   <= '1;
      col_out_q   <= '0;
      tick_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      pos_row_q   <= '0;
      pos_col_q   <= '0;
      for (int i = 0; i < NPIX; i++) fb_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sc_q        <= sc_d;
      mode_q      <= mode_d;
      color_q     <= color_d;
      hit_done_q  <= hit_done_d;
      pen_s1_q    <= bus.pen_i;
      pen_s2_q    <= pen_s1_q;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
      tick_q      <= tick_d;
      pos_valid_q <= hit;
      if (hit) begin
        pos_row_q <= row_q;
        pos_col_q <= col_q;
      end
      if (clr_busy_q) begin
        fb_q[clr_addr_q] <= '0;
        clr_addr_q       <= clr_addr_q + 1'b1;
        if (clr_addr_q == PIX_LAST) clr_busy_q <= 1'b0;
      end else if (clear_start) begin
        clr_busy_q <= 1'b1;
        clr_addr_q <= '0;
      end else if (hit) begin
        fb_q[pix_addr(row_q, int'(col_q))] <= (mode_q == 2'd1) ? color_q : '0;
      end
    end
  end

  assign bus.row_o      = row_out_q;
  assign bus.col_o      = col_out_q;
  assign bus.pos_valid  = pos_valid_q;
  assign bus.pos_row    = pos_row_q;
  assign bus.pos_col    = pos_col_q;
  assign bus.clear_busy = clr_busy_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_pen_matrix_ctrl.sv
// Directed bench for pen_matrix_ctrl at ROWS=COLS=4, CH=2, SLOT_CYC=8, BLANK_CYC=2.
// Position g counts clocks from the start of a frame; outputs are sampled 1 time unit after posedge.
module tb_pen_matrix_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int g = 0;

  pen_matrix_if #(.ROWS(4), .COLS(4), .CH(2)) bus ();

  pen_matrix_ctrl #(.ROWS(4), .COLS(4), .CH(2), .SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic goto(input int t);
    while (g < t) step(1);
  endtask

  task automatic restart();
    bus.en = 1'b0;
    step(1);
    bus.en = 1'b1;
    g = 0;
  endtask

  function automatic logic [3:0] view_row(input int t);
    logic [3:0] one;
    one = 4'b0001;
    if (t % 8 < 2) return 4'b1111;
    return ~(one << ((t / 8) % 4));
  endfunction

  task automatic test_reset();
    compared++; if (bus.row_o !== 4'b1111) begin mismatched++; $display("FAIL reset_row got %b want 1111", bus.row_o); end
    compared++; if (bus.col_o !== 8'h00) begin mismatched++; $display("FAIL reset_col got %b want 0", bus.col_o); end
    compared++; if (bus.pos_valid !== 1'b0) begin mismatched++; $display("FAIL reset_pos_valid got %b want 0", bus.pos_valid); end
    compared++; if (bus.clear_busy !== 1'b0) begin mismatched++; $display("FAIL reset_clear_busy got %b want 0", bus.clear_busy); end
    compared++; if (bus.frame_tick !== 1'b0) begin mismatched++; $display("FAIL reset_frame_tick got %b want 0", bus.frame_tick); end
    compared++; if ({bus.pos_row, bus.pos_col} !== 4'h0) begin mismatched++; $display("FAIL reset_pos got %0d,%0d want 0,0", bus.pos_row, bus.pos_col); end
  endtask

  task automatic test_view_scan();
    bus.mode = 2'd0;
    restart();
    for (int t = 0; t <= 64; t++) begin
      goto(t);
      compared++; if (bus.row_o !== view_row(t)) begin mismatched++; $display("FAIL view_row t=%0d got %b want %b", t, bus.row_o, view_row(t)); end
      compared++; if (bus.col_o !== 8'h00) begin mismatched++; $display("FAIL view_col t=%0d got %b want 0", t, bus.col_o); end
      compared++; if (bus.frame_tick !== (t % 32 == 31)) begin mismatched++; $display("FAIL view_tick t=%0d got %b want %b", t, bus.frame_tick, (t % 32 == 31)); end
    end
  endtask

  task automatic test_draw();
    int npv = 0;
    bus.mode = 2'd1; bus.color = 2'b01;
    restart();
    for (int t = 0; t <= 159; t++) begin
      goto(t);
      if (bus.pos_valid === 1'b1) begin
        npv++;
        compared++; if (t != 112 || bus.pos_row !== 2'd2 || bus.pos_col !== 2'd1) begin mismatched++; $display("FAIL draw_hit t=%0d got %0d,%0d want t=112 2,1", t, bus.pos_row, bus.pos_col); end
      end
      if (t == 107) begin
        compared++; if (bus.row_o !== 4'b1011 || bus.col_o !== 8'b0010_0010) begin mismatched++; $display("FAIL probe_drive got %b/%b want 1011/00100010", bus.row_o, bus.col_o); end
      end
      if (t == 104) bus.pen_i = 1'b1;
      if (t == 112) bus.pen_i = 1'b0;
    end
    compared++; if (bus.frame_tick !== 1'b1) begin mismatched++; $display("FAIL draw_tick159 got %b want 1", bus.frame_tick); end
    compared++; if (npv != 1) begin mismatched++; $display("FAIL draw_hit_count got %0d want 1", npv); end
    goto(178);
    compared++; if (bus.row_o !== 4'b1011 || bus.col_o !== 8'b0000_0010) begin mismatched++; $display("FAIL draw_display got %b/%b want 1011/00000010", bus.row_o, bus.col_o); end
  endtask

  task automatic test_erase();
    bus.mode = 2'd2;
    restart();
    goto(18);
    compared++; if (bus.col_o !== 8'b0000_0010) begin mismatched++; $display("FAIL erase_before got %b want 00000010", bus.col_o); end
    goto(104); bus.pen_i = 1'b1;
    goto(112); bus.pen_i = 1'b0;
    compared++; if (bus.pos_valid !== 1'b1 || bus.pos_row !== 2'd2 || bus.pos_col !== 2'd1) begin mismatched++; $display("FAIL erase_hit got v=%b %0d,%0d want 1 2,1", bus.pos_valid, bus.pos_row, bus.pos_col); end
    goto(178);
    compared++; if (bus.row_o !== 4'b1011 || bus.col_o !== 8'h00) begin mismatched++; $display("FAIL erase_display got %b/%b want 1011/0", bus.row_o, bus.col_o); end
  endtask

  task automatic test_pen_held();
    int npv = 0;
    int nticks = 0;
    bus.mode = 2'd1; bus.color = 2'b11;
    restart();
    bus.pen_i = 1'b1;
    for (int t = 0; t <= 319; t++) begin
      goto(t);
      if (bus.pos_valid === 1'b1) begin
        npv++;
        compared++; if ((t != 40 && t != 200) || bus.pos_row !== 2'd0 || bus.pos_col !== 2'd0) begin mismatched++; $display("FAIL held_hit t=%0d got %0d,%0d want t=40/200 0,0", t, bus.pos_row, bus.pos_col); end
      end
      if (bus.frame_tick === 1'b1) begin
        nticks++;
        compared++; if (t != 159 && t != 319) begin mismatched++; $display("FAIL held_tick got t=%0d want 159/319", t); end
      end
    end
    bus.pen_i = 1'b0;
    compared++; if (npv != 2) begin mismatched++; $display("FAIL held_hit_count got %0d want 2", npv); end
    compared++; if (nticks != 2) begin mismatched++; $display("FAIL held_tick_count got %0d want 2", nticks); end
  endtask

  task automatic test_clear();
    bus.mode = 2'd1; bus.color = 2'b10;
    restart();
    goto(2);
    compared++; if (bus.col_o !== 8'b0001_0001) begin mismatched++; $display("FAIL clear_before got %b want 00010001", bus.col_o); end
    for (int t = 95; t <= 125; t++) begin
      goto(t);
      compared++; if (bus.clear_busy !== (t >= 101 && t <= 116)) begin mismatched++; $display("FAIL clear_busy t=%0d got %b want %b", t, bus.clear_busy, (t >= 101 && t <= 116)); end
      if (t == 112) begin
        compared++; if (bus.pos_valid !== 1'b1 || bus.pos_row !== 2'd2 || bus.pos_col !== 2'd1) begin mismatched++; $display("FAIL clear_hit got v=%b %0d,%0d want 1 2,1", bus.pos_valid, bus.pos_row, bus.pos_col); end
      end
      if (t == 100 || t == 105) bus.clear = 1'b1;
      if (t == 101 || t == 106) bus.clear = 1'b0;
      if (t == 104) bus.pen_i = 1'b1;
      if (t == 112) bus.pen_i = 1'b0;
    end
    goto(162);
    compared++; if (bus.row_o !== 4'b1110 || bus.col_o !== 8'h00) begin mismatched++; $display("FAIL clear_row0 got %b/%b want 1110/0", bus.row_o, bus.col_o); end
    goto(178);
    compared++; if (bus.row_o !== 4'b1011 || bus.col_o !== 8'h00) begin mismatched++; $display("FAIL clear_row2 got %b/%b want 1011/0", bus.row_o, bus.col_o); end
  endtask

  task automatic test_reset_mid();
    bus.mode = 2'd1; bus.color = 2'b01;
    restart();
    goto(152); bus.pen_i = 1'b1;
    goto(160); bus.pen_i = 1'b0;
    compared++; if (bus.pos_valid !== 1'b1 || bus.pos_row !== 2'd3 || bus.pos_col !== 2'd3) begin mismatched++; $display("FAIL mid_hit got v=%b %0d,%0d want 1 3,3", bus.pos_valid, bus.pos_row, bus.pos_col); end
    goto(186);
    compared++; if (bus.col_o !== 8'b0000_1000) begin mismatched++; $display("FAIL mid_display got %b want 00001000", bus.col_o); end
    goto(245); bus.clear = 1'b1;
    goto(246); bus.clear = 1'b0;
    compared++; if (bus.clear_busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy got %b want 1", bus.clear_busy); end
    goto(250);
    compared++; if (bus.row_o !== 4'b1101 || bus.col_o !== 8'b1000_1000) begin mismatched++; $display("FAIL mid_probe got %b/%b want 1101/10001000", bus.row_o, bus.col_o); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (bus.row_o !== 4'b1111 || bus.col_o !== 8'h00) begin mismatched++; $display("FAIL async_pins got %b/%b want 1111/0", bus.row_o, bus.col_o); end
    compared++; if (bus.clear_busy !== 1'b0 || bus.pos_valid !== 1'b0 || bus.frame_tick !== 1'b0) begin mismatched++; $display("FAIL async_flags got %b%b%b want 000", bus.clear_busy, bus.pos_valid, bus.frame_tick); end
    compared++; if ({bus.pos_row, bus.pos_col} !== 4'h0) begin mismatched++; $display("FAIL async_pos got %0d,%0d want 0,0", bus.pos_row, bus.pos_col); end
    bus.mode = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    g = 0;
    goto(2);
    compared++; if (bus.row_o !== 4'b1110) begin mismatched++; $display("FAIL restart_row0 got %b want 1110", bus.row_o); end
    goto(26);
    compared++; if (bus.row_o !== 4'b0111 || bus.col_o !== 8'h00) begin mismatched++; $display("FAIL restart_fb got %b/%b want 0111/0", bus.row_o, bus.col_o); end
    compared++; if (bus.clear_busy !== 1'b0) begin mismatched++; $display("FAIL restart_busy got %b want 0", bus.clear_busy); end
  endtask

  initial begin
    bus.en = 1'b0; bus.mode = 2'd0; bus.color = 2'b00; bus.clear = 1'b0; bus.pen_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step(1);
    test_view_scan();
    test_draw();
    test_erase();
    test_pen_held();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
